// File: rtl/exec_pkg.sv
// Shared definitions for the execute datapath: writeback source encodings
// and default sizing constants.
package exec_pkg;

  localparam int unsigned DEF_WIDTH = 32;
  localparam int unsigned DEF_NREGS = 32;

  typedef enum logic [1:0] {
    WB_ALU  = 2'd0,
    WB_MEM  = 2'd1,
    WB_IMM  = 2'd2,
    WB_NONE = 2'd3
  } wb_sel_e;

endpackage : exec_pkg

// File: rtl/exec_datapath_regbank.sv
// Register storage: two combinational read ports, one synchronous write port,
// synchronous clear. Entry 0 is never written so it always reads zero.
module regbank #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned NREGS = 32,
  localparam int unsigned AW   = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [AW-1:0]    raddr1_i,
  input  logic [AW-1:0]    raddr2_i,
  output logic [WIDTH-1:0] rdata1_o,
  output logic [WIDTH-1:0] rdata2_o,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i
);

  logic [WIDTH-1:0] mem_q [NREGS];

  assign rdata1_o = mem_q[raddr1_i];
  assign rdata2_o = mem_q[raddr2_i];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i && (waddr_i != '0)) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

endmodule : regbank

// File: rtl/exec_datapath.sv
// Two-stage execute datapath: operand read with forwarding, ALU and writeback
// select into a pending-result register, then commit into the register bank.
module exec_datapath
  import exec_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned NREGS = DEF_NREGS,
  localparam int unsigned AW   = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             issue,
  input  logic             wb,
  input  logic [1:0]       wb_sel,
  input  logic             alu_sum,
  input  logic [AW-1:0]    dest,
  input  logic [AW-1:0]    source1,
  input  logic [AW-1:0]    source2,
  input  logic [WIDTH-1:0] mem_data,
  input  logic [WIDTH-1:0] imm,
  input  logic             set_st,
  input  logic             reset_st,
  input  logic             cmp,
  output logic [WIDTH-1:0] rd1,
  output logic [WIDTH-1:0] rd2,
  output logic [WIDTH-1:0] result,
  output logic             res_valid,
  output logic             eq,
  output logic             lt
);

  logic [WIDTH-1:0] result_q, result_d;
  logic [AW-1:0]    pend_dest_q, pend_dest_d;
  logic             res_valid_q, res_valid_d;
  logic             eq_q, eq_d;
  logic             lt_q, lt_d;

  logic [WIDTH-1:0] bank_rd1, bank_rd2;
  logic [WIDTH-1:0] alu_out;
  logic [WIDTH-1:0] wb_val;
  logic             wr_go;
  wb_sel_e          sel;

  regbank #(
    .WIDTH (WIDTH),
    .NREGS (NREGS)
  ) u_bank (
    .clk      (clk),
    .reset    (reset),
    .raddr1_i (source1),
    .raddr2_i (source2),
    .rdata1_o (bank_rd1),
    .rdata2_o (bank_rd2),
    .we_i     (res_valid_q),
    .waddr_i  (pend_dest_q),
    .wdata_i  (result_q)
  );

  // Forward the pending result over a bank read of the same non-zero register.
  assign rd1 = (res_valid_q && (pend_dest_q == source1) && (source1 != '0)) ? result_q : bank_rd1;
  assign rd2 = (res_valid_q && (pend_dest_q == source2) && (source2 != '0)) ? result_q : bank_rd2;

  assign alu_out = alu_sum ? (rd1 + rd2) : (rd1 - rd2);
  assign sel     = wb_sel_e'(wb_sel);
  assign wr_go   = issue && wb && (sel != WB_NONE);

  always_comb begin
    wb_val = '0;
    case (sel)
      WB_ALU:  wb_val = alu_out;
      WB_MEM:  wb_val = mem_data;
      WB_IMM:  wb_val = imm;
      default: wb_val = '0;
    endcase
  end

  // Stage-1 capture and status flag update.
  always_comb begin
    result_d    = result_q;
    pend_dest_d = pend_dest_q;
    res_valid_d = 1'b0;
    eq_d        = eq_q;
    lt_d        = lt_q;
    if (wr_go) begin
      result_d    = wb_val;
      pend_dest_d = dest;
      res_valid_d = 1'b1;
    end
    if (issue) begin
      if (reset_st) begin
        eq_d = 1'b0;
        lt_d = 1'b0;
      end else if (set_st) begin
        eq_d = 1'b1;
        lt_d = 1'b1;
      end else if (cmp) begin
        eq_d = (rd1 == rd2);
        lt_d = ($signed(rd1) < $signed(rd2));
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      result_q    <= '0;
      pend_dest_q <= '0;
      res_valid_q <= 1'b0;
      eq_q        <= 1'b0;
      lt_q        <= 1'b0;
    end else begin
      result_q    <= result_d;
      pend_dest_q <= pend_dest_d;
      res_valid_q <= res_valid_d;
      eq_q        <= eq_d;
      lt_q        <= lt_d;
    end
  end

  assign result    = result_q;
  assign res_valid = res_valid_q;
  assign eq        = eq_q;
  assign lt        = lt_q;

endmodule : exec_datapath

// File: tb/tb_exec_datapath.sv
// Bench for exec_datapath at WIDTH=8, NREGS=8: architectural register model
// checked every cycle plus directed literal expectations.
module tb_exec_datapath;

  logic       clk = 1'b0;
  logic       reset;
  logic       issue, wb, alu_sum, set_st, reset_st, cmp;
  logic [1:0] wb_sel;
  logic [2:0] dest, source1, source2;
  logic [7:0] mem_data, imm;
  logic [7:0] rd1, rd2, result;
  logic       res_valid, eq, lt;

  int checks   = 0;
  int failures = 0;

  exec_datapath #(.WIDTH(8), .NREGS(8)) dut (
    .clk(clk), .reset(reset), .issue(issue), .wb(wb), .wb_sel(wb_sel),
    .alu_sum(alu_sum), .dest(dest), .source1(source1), .source2(source2),
    .mem_data(mem_data), .imm(imm), .set_st(set_st), .reset_st(reset_st),
    .cmp(cmp), .rd1(rd1), .rd2(rd2), .result(result), .res_valid(res_valid),
    .eq(eq), .lt(lt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%02h required=%02h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Architectural model: every issued write is visible to the very next read.
  logic [7:0] m_reg [8];
  logic [7:0] m_res;
  logic       m_val, m_eq, m_lt, m_on = 1'b0;

  function automatic logic [7:0] rv(input logic [2:0] a);
    return (a == 3'd0) ? 8'd0 : m_reg[a];
  endfunction

  function automatic logic m_go();
    return issue && wb && (wb_sel != 2'd3);
  endfunction

  function automatic logic [7:0] m_wbv();
    if (wb_sel == 2'd1) return mem_data;
    if (wb_sel == 2'd2) return imm;
    return alu_sum ? 8'(rv(source1) + rv(source2)) : 8'(rv(source1) - rv(source2));
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) m_reg[i] <= 8'd0;
      m_res <= 8'd0;
      m_val <= 1'b0;
      m_eq  <= 1'b0;
      m_lt  <= 1'b0;
      m_on  <= 1'b1;
    end else begin
      m_val <= m_go();
      if (m_go()) begin
        m_res <= m_wbv();
        if (dest != 3'd0) m_reg[dest] <= m_wbv();
      end
      if (issue) begin
        if (reset_st) begin
          m_eq <= 1'b0; m_lt <= 1'b0;
        end else if (set_st) begin
          m_eq <= 1'b1; m_lt <= 1'b1;
        end else if (cmp) begin
          m_eq <= (rv(source1) == rv(source2));
          m_lt <= ($signed(rv(source1)) < $signed(rv(source2)));
        end
      end
    end
  end

  always @(negedge clk) begin
    if (m_on) begin
      chk("model_rd1", rd1, rv(source1));
      chk("model_rd2", rd2, rv(source2));
      chk("model_res_valid", 8'(res_valid), 8'(m_val));
      chk("model_result", result, m_res);
      chk("model_eq", 8'(eq), 8'(m_eq));
      chk("model_lt", 8'(lt), 8'(m_lt));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic [2:0] s1, input logic [2:0] s2);
    issue = 0; wb = 0; wb_sel = 2'd0; alu_sum = 0; set_st = 0; reset_st = 0; cmp = 0;
    dest = 3'd0; source1 = s1; source2 = s2; mem_data = 8'd0; imm = 8'd0;
  endtask

  task automatic put_wb(input logic [1:0] sel, input logic [2:0] d, input logic [7:0] v,
                        input logic [2:0] s1);
    idle(s1, 3'd0);
    issue = 1; wb = 1; wb_sel = sel; dest = d; mem_data = v; imm = ~v;
    if (sel == 2'd2) imm = v;
    if (sel == 2'd2) mem_data = ~v;
  endtask

  task automatic put_alu(input logic add, input logic [2:0] d, input logic [2:0] s1,
                         input logic [2:0] s2);
    idle(s1, s2);
    issue = 1; wb = 1; wb_sel = 2'd0; alu_sum = add; dest = d;
  endtask

  task automatic put_cmp(input logic [2:0] s1, input logic [2:0] s2, input logic sst,
                         input logic rst);
    idle(s1, s2);
    issue = 1; cmp = 1; set_st = sst; reset_st = rst;
  endtask

  initial begin
    reset = 1;
    idle(3'd0, 3'd0);
    tick(); tick();
    reset = 0;
    @(negedge clk);
    chk("reset_res_valid", 8'(res_valid), 8'd0);
    chk("reset_result", result, 8'd0);
    chk("reset_eq_lt", 8'({eq, lt}), 8'd0);

    // imm write to r1: forwarded after one edge, in the bank after two
    tick(); put_wb(2'd2, 3'd1, 8'h05, 3'd0);
    tick(); idle(3'd1, 3'd0);
    @(negedge clk);
    chk("imm_result", result, 8'h05);
    chk("imm_valid", 8'(res_valid), 8'd1);
    chk("imm_fwd_rd1", rd1, 8'h05);
    chk("imm_r0_rd2", rd2, 8'h00);
    tick();
    @(negedge clk);
    chk("imm_bank_valid", 8'(res_valid), 8'd0);
    chk("imm_bank_rd1", rd1, 8'h05);

    // forwarded operands into an add
    tick(); put_wb(2'd2, 3'd2, 8'h07, 3'd0);
    tick(); put_alu(1'b1, 3'd3, 3'd2, 3'd2);
    @(negedge clk);
    chk("fwd_rd1", rd1, 8'h07);
    chk("fwd_rd2", rd2, 8'h07);
    tick(); idle(3'd3, 3'd0);
    tick();
    @(negedge clk);
    chk("add_bank_r3", rd1, 8'h0E);

    // modulo wrap in both directions
    tick(); put_wb(2'd2, 3'd1, 8'hFF, 3'd0);
    tick(); put_wb(2'd2, 3'd2, 8'h01, 3'd0);
    tick(); put_alu(1'b1, 3'd4, 3'd1, 3'd2);
    tick(); put_alu(1'b0, 3'd5, 3'd2, 3'd1);
    tick(); idle(3'd4, 3'd5);
    tick();
    @(negedge clk);
    chk("wrap_add_r4", rd1, 8'h00);
    chk("wrap_sub_r5", rd2, 8'h02);

    // status flags: signed compare and priorities
    tick(); put_cmp(3'd1, 3'd2, 1'b0, 1'b0);
    tick(); idle(3'd0, 3'd0);
    @(negedge clk);
    chk("cmp_neg_eq_lt", 8'({eq, lt}), 8'b01);
    tick(); put_cmp(3'd1, 3'd1, 1'b1, 1'b1);
    tick(); idle(3'd0, 3'd0);
    @(negedge clk);
    chk("rst_over_set", 8'({eq, lt}), 8'b00);
    tick(); put_cmp(3'd1, 3'd2, 1'b1, 1'b0);
    tick(); idle(3'd0, 3'd0);
    @(negedge clk);
    chk("set_over_cmp", 8'({eq, lt}), 8'b11);
    tick(); put_cmp(3'd2, 3'd1, 1'b0, 1'b0);
    tick(); idle(3'd1, 3'd1); cmp = 1;
    @(negedge clk);
    chk("cmp_pos_vs_neg", 8'({eq, lt}), 8'b00);
    tick(); put_cmp(3'd1, 3'd1, 1'b0, 1'b0);
    tick(); idle(3'd1, 3'd2); cmp = 1;
    tick();
    @(negedge clk);
    chk("cmp_equal_hold", 8'({eq, lt}), 8'b10);

    // write to r0 is discarded yet still flagged pending
    tick(); put_wb(2'd2, 3'd0, 8'h09, 3'd0);
    @(negedge clk);
    chk("r0_pre_rd1", rd1, 8'h00);
    tick(); idle(3'd0, 3'd0);
    @(negedge clk);
    chk("r0_valid", 8'(res_valid), 8'd1);
    chk("r0_result", result, 8'h09);
    chk("r0_rd1", rd1, 8'h00);
    tick();
    @(negedge clk);
    chk("r0_bank", rd1, 8'h00);

    // back-to-back writes to one dest, then reserved source and mem source
    tick(); put_wb(2'd2, 3'd3, 8'h11, 3'd0);
    tick(); put_wb(2'd2, 3'd3, 8'h22, 3'd3);
    @(negedge clk);
    chk("b2b_old_fwd", rd1, 8'h11);
    tick(); idle(3'd3, 3'd0);
    @(negedge clk);
    chk("b2b_new_fwd", rd1, 8'h22);
    tick();
    @(negedge clk);
    chk("b2b_bank", rd1, 8'h22);
    tick(); put_wb(2'd3, 3'd3, 8'h77, 3'd0);
    tick(); idle(3'd3, 3'd0);
    @(negedge clk);
    chk("reserved_valid", 8'(res_valid), 8'd0);
    chk("reserved_rd1", rd1, 8'h22);
    tick(); put_wb(2'd1, 3'd6, 8'hA5, 3'd0);
    tick(); idle(3'd6, 3'd0);
    tick();
    @(negedge clk);
    chk("mem_bank_r6", rd1, 8'hA5);

    // issue coinciding with reset is ignored
    tick(); reset = 1; put_wb(2'd2, 3'd7, 8'h33, 3'd0);
    tick(); reset = 0; idle(3'd7, 3'd1);
    @(negedge clk);
    chk("rst_issue_valid", 8'(res_valid), 8'd0);
    chk("rst_issue_r7", rd1, 8'h00);
    chk("rst_clear_r1", rd2, 8'h00);

    // pending write discarded by reset
    tick(); put_wb(2'd2, 3'd6, 8'h55, 3'd0);
    tick(); reset = 1; idle(3'd6, 3'd0);
    tick(); reset = 0;
    @(negedge clk);
    chk("inflight_valid", 8'(res_valid), 8'd0);
    chk("inflight_r6", rd1, 8'h00);
    tick();
    @(negedge clk);
    chk("inflight_r6_later", rd1, 8'h00);

    tick(); tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_exec_datapath

// File: doc/exec_datapath.md
EXEC_DATAPATH -- requirements
Module: exec_datapath

Interface
REQ-001 Parameter WIDTH, default 32, data width of registers, operands and result.
REQ-002 Parameter NREGS, default 32, register count; power of two, minimum 4.
REQ-003 Parameter AW, default $clog2(NREGS), register address width; derived, never overridden.
REQ-004 Port clk, input, 1: single clock, all state on rising edge.
REQ-005 Port reset, input, 1: synchronous, active-high reset.
REQ-006 Port issue, input, 1: an instruction is presented this cycle.
REQ-007 Port wb, input, 1: the issued instruction writes back to dest.
REQ-008 Port wb_sel, input, 2: writeback source; 0 = ALU, 1 = mem_data, 2 = imm, 3 = reserved (no write).
REQ-009 Port alu_sum, input, 1: ALU mode; 1 = src1+src2, 0 = src1-src2.
REQ-010 Port dest / source1 / source2, input, AW each: register addresses.
REQ-011 Port mem_data / imm, input, WIDTH each: writeback data for wb_sel 1 / 2.
REQ-012 Port set_st / reset_st / cmp, input, 1 each: force status flags to 1 / force them to 0 / load them from comparison.
REQ-013 Port rd1 / rd2, output, WIDTH each: forwarded operand values, combinational.
REQ-014 Port result, output, WIDTH: registered writeback value.
REQ-015 Port res_valid, output, 1: result holds a pending write.
REQ-016 Port eq / lt, output, 1 each: status flags; lt is a signed comparison.

Function
REQ-017 Register 0 SHALL read as zero; writes to it are discarded, with res_valid still asserted.
REQ-018 rd1/rd2 SHALL return bank[source], replaced by result when res_valid=1, the pending dest equals source, and source != 0.
REQ-019 Stage 1: when issue=1, wb=1 and wb_sel!=3, result and the pending dest SHALL be registered on the next edge and res_valid set to 1; otherwise res_valid=0.
REQ-020 Stage 2: when res_valid=1, the bank SHALL be written on the next edge; the write is visible in the bank two edges after issue and via forwarding one edge after issue.
REQ-021 ALU arithmetic SHALL be modulo 2^WIDTH; carry and overflow are dropped.
REQ-022 Back-to-back issues to the same dest SHALL forward the newest pending value; the older value is still written first.
REQ-023 Status update priority on issue=1: reset_st > set_st > cmp; eq = (rd1==rd2) and lt = ($signed(rd1) < $signed(rd2)), both from forwarded operands.
REQ-024 When issue=0, the bank, the status flags, and all other state except res_valid SHALL hold.
REQ-025 A source address equal to a dest written in the same cycle SHALL read the old or forwarded value, never the new stage-1 value.

Reset
REQ-026 On reset: res_valid=0, result=0, eq=0, lt=0, and all bank entries = 0 on the next edge.
REQ-027 A pending write in flight when reset asserts SHALL be discarded.
REQ-028 An issue coinciding with reset SHALL be ignored.

Structure
REQ-029 Shared package exec_pkg SHALL hold the wb_sel encodings (WB_ALU, WB_MEM, WB_IMM, WB_NONE) and default WIDTH/NREGS constants.
REQ-030 Register storage SHALL be one sub-module, regbank (two combinational read ports, one synchronous write port, reset-clear); forwarding and the ALU stay in exec_datapath.

Verification
REQ-031 Reset, then issue wb=1, wb_sel=2, imm=5, dest=1 -> result=5 and res_valid=1 after 1 edge; bank[1]=5 after 2 edges; bank[0]=0 throughout.
REQ-032 Issue imm=7 to r2, then next cycle issue ALU add with source1=2, source2=2, dest=3 -> rd1=rd2=7 via forwarding; bank[3]=14.
REQ-033 With WIDTH=8: r1=8'hFF, r2=1, ALU add to r4 -> bank[4]=8'h00; subtract r2-r1 to r5 -> bank[5]=8'h02.
REQ-034 cmp with r1=-1 (all ones), r2=1 -> eq=0, lt=1; same cycle set_st=1 and reset_st=1 -> eq=0, lt=0.
REQ-035 Write imm=9 to dest=0 -> res_valid=1, rd1 for source1=0 stays 0, bank[0] stays 0.
REQ-036 Issue a write, assert reset on the following edge -> the bank entry stays 0, res_valid=0.
